updown_counter_ctrl: RTL and testbench
======================================

# updown_counter_ctrl

Parametrised run/stop up/down counter with an integrated tick prescaler, synchronous clear, saturating parallel load and wrap reporting. It is the generalised successor of the fixed 10 Hz, 0–9999 counter. It sits between the switch/button debouncers and the FND/display datapath. Tick rate, terminal value and width are set per instance.

## Interface
- CLK_HZ, 100_000_000, input clock frequency in Hz
- TICK_HZ, 10, count step rate in Hz; DIV = CLK_HZ/TICK_HZ (localparam), must be ≥ 1
- MAX_COUNT, 9999, terminal value; the count range is 0..MAX_COUNT
- WIDTH, 14, count width; MAX_COUNT < 2**WIDTH is required (elaboration-time assertion)
- clk  input  1  system clock; the block uses one clock
- reset  input  1  asynchronous, active-high reset
- run  input  1  level; 1 = count, 0 = hold
- mode  input  1  0 = up, 1 = down; sampled at every step
- clear  input  1  synchronous one-cycle clear request
- load  input  1  synchronous one-cycle load request
- load_value  input  WIDTH  value to load
- count  output  WIDTH  current count
- running  output  1  1 while the FSM is in RUN
- step  output  1  one-cycle pulse per count update
- wrap  output  1  one-cycle pulse when the count wraps (MAX_COUNT→0 up, 0→MAX_COUNT down)

## Operation
- FSM states: ST_STOP and ST_RUN. Reset state is ST_STOP.
  - ST_STOP→ST_RUN when run=1 is sampled.
  - ST_RUN→ST_STOP when run=0 is sampled.
- Prescaler div_cnt, width max(1,$clog2(DIV)):
  - Forced to 0 on reset, on entering ST_RUN, on clear and on load.
  - In ST_RUN it increments each cycle. At DIV-1 it returns to 0 and issues a step enable.
  - In ST_STOP it holds at 0. Phase is not preserved across a stop.
- Step rules:
  - Up: count+1, or 0 if count==MAX_COUNT (wrap).
  - Down: count-1, or MAX_COUNT if count==0 (wrap).
- Load: count <= min(load_value, MAX_COUNT), i.e. saturating.
- Clear: count <= 0. Clear does not change the FSM state.
- Priority on a single edge: reset > clear > load > step. A step coinciding with clear or load is discarded. step and wrap are not asserted in that case.
- A mode change while running takes effect at the next step. There is no glitch and no extra step.
- All arithmetic is WIDTH bits unsigned. Comparisons are against MAX_COUNT, never against 2**WIDTH-1.

## Timing
- Reset values: count=0, running=0, step=0, wrap=0, state ST_STOP, div_cnt=0.
- run=1 is sampled at edge k. running=1 after edge k. The first step occurs at edge k+DIV, then every DIV cycles.
- run=0 is sampled at edge j. running=0 after edge j. No step occurs at edge j or later.
- step and wrap are registered. Each is high for exactly the one cycle following the updating edge, aligned with the new count value.
- clear and load take effect at the sampling edge, so the new count is visible the next cycle. After either, the next step occurs DIV cycles later if still running.
- DIV==1: a step occurs on every edge in ST_RUN.
- Reset asserted mid-operation returns all outputs to their reset values immediately (asynchronously). After deassertion the FSM needs a fresh run sample.

## Structure
- Package updown_pkg holds:
  - typedef enum logic {ST_STOP, ST_RUN} state_t
  - localparams MODE_UP=1'b0 and MODE_DOWN=1'b1
- Sub-module tick_gen (parameter DIV) carries the prescaler: inputs clk, reset, en, restart; output tick (combinational, high when div_cnt==DIV-1 && en).
- The top level holds the FSM, the count register and the step/wrap output registers.

## Test plan
Bench parameters: CLK_HZ=100, TICK_HZ=10 (DIV=10), MAX_COUNT=9, WIDTH=4.
- Reset, then run=1 at edge 0, mode=0 → count steps at edges 10, 20, …. At edge 100, count 9→0 with wrap=1 for one cycle; step pulses every 10 cycles.
- mode=1 from count=0 with run=1 → first step gives count=9 with wrap=1. Then 8, 7 at 10-cycle spacing.
- run dropped at count=3 for 25 cycles, then raised → count holds 3, running=0. The next step comes 10 cycles after the run sample, giving 4.
- load=1 with load_value=13 → count=9 (saturated). load_value=5 coinciding with a step edge → count=5, no step and no wrap pulse.
- clear and load asserted together at count=7 → count=0. Asserting reset mid-run at count=6 → all outputs return to 0 asynchronously.
- mode toggled 3 cycles before a step at count=4 → that step gives 3. No double step; spacing stays 10 cycles.

Source files
------------

// File: rtl/updown_pkg.sv
// -----------------------------------------------------------------------------
// updown_pkg
// Shared types and constants for the up/down counter controller.
//   state_t   : run/stop FSM encoding
//   MODE_UP   : value of the mode input that selects counting up
//   MODE_DOWN : value of the mode input that selects counting down
// -----------------------------------------------------------------------------
package updown_pkg;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage : updown_pkg

// File: rtl/updown_counter_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler producing one tick every DIV enabled cycles.
//   clk     : system clock
//   reset   : asynchronous, active-high reset
//   en      : count enable; while low the divider is held at 0
//   restart : synchronous restart of the divider phase (forces 0)
//   tick    : combinational, high when the divider is at its last phase and
//             en is high
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  // A one-bit divider is kept for DIV==1 so the port widths stay legal;
  // it simply sits at 0 and every enabled cycle is a tick.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (restart || !en) begin
      // Phase is deliberately not preserved across stop/clear/load.
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = en && (div_cnt == LAST);

endmodule : tick_gen

// File: rtl/updown_counter_ctrl.sv
// -----------------------------------------------------------------------------
// updown_counter_ctrl
// Run/stop up/down counter over 0..MAX_COUNT with an integrated prescaler,
// synchronous clear, saturating load and wrap reporting.
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   run        : level, 1 = count, 0 = hold
//   mode       : 0 = up, 1 = down, sampled at every step
//   clear      : one-cycle synchronous clear (count <= 0)
//   load       : one-cycle synchronous load (count <= min(load_value, MAX))
//   load_value : value to load
//   count      : current count
//   running    : 1 while the FSM is in ST_RUN
//   step       : one-cycle pulse aligned with each stepped count value
//   wrap       : one-cycle pulse when a step wrapped around the range
// Edge priority: reset > clear > load > step; a step that coincides with
// clear or load is dropped together with its step/wrap pulses.
// -----------------------------------------------------------------------------
module updown_counter_ctrl
  import updown_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 10,
  parameter int MAX_COUNT = 9999,
  parameter int WIDTH     = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             step,
  output logic             wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  if (MAX_COUNT >= (2 ** WIDTH)) begin : g_bad_width
    $error("updown_counter_ctrl: MAX_COUNT does not fit in WIDTH bits");
  end
  if (DIV < 1) begin : g_bad_div
    $error("updown_counter_ctrl: CLK_HZ/TICK_HZ must be at least 1");
  end

  // FSM state, kept as a named signal so checkers can bind to it.
  state_t state;

  logic tick;
  logic tick_en;
  logic tick_restart;

  // The divider only advances while running and run is still high, so no
  // step can land on the edge that samples run=0. Sitting in ST_STOP keeps
  // it at 0, which gives the first step exactly DIV edges after run is seen.
  assign tick_en      = (state == ST_RUN) && run;
  assign tick_restart = clear || load || (state == ST_STOP);

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (tick_en),
    .restart (tick_restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_STOP;
      running <= 1'b0;
      count   <= '0;
      step    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;

      case (state)
        ST_STOP: begin
          if (run) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!run) begin
            state   <= ST_STOP;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= ST_STOP;
          running <= 1'b0;
        end
      endcase

      if (clear) begin
        count <= '0;
      end else if (load) begin
        count <= (load_value > MAX_C) ? MAX_C : load_value;
      end else if (tick) begin
        step <= 1'b1;
        if (mode == MODE_UP) begin
          if (count == MAX_C) begin
            count <= '0;
            wrap  <= 1'b1;
          end else begin
            count <= count + WIDTH'(1);
          end
        end else begin
          if (count == '0) begin
            count <= MAX_C;
            wrap  <= 1'b1;
          end else begin
            count <= count - WIDTH'(1);
          end
        end
      end
    end
  end

endmodule : updown_counter_ctrl

// File: tb/tb_updown_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_ctrl
// Directed bench for updown_counter_ctrl with DIV=10, MAX_COUNT=9, WIDTH=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point. "Edge n" counts rising edges from the edge that first samples
// run=1 (edge 0).
// -----------------------------------------------------------------------------
module tb_updown_counter_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         run;
  logic         mode;
  logic         clear;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         running;
  logic         step;
  logic         wrap;

  int checks   = 0;
  int failures = 0;
  int cur      = 0;

  updown_counter_ctrl #(
    .CLK_HZ    (100),
    .TICK_HZ   (10),
    .MAX_COUNT (9),
    .WIDTH     (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .mode       (mode),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .running    (running),
    .step       (step),
    .wrap       (wrap)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached (observed timeout, required finish)");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  // Advance to just after edge e.
  task automatic go_to(input int e);
    while (cur < e) begin
      @(posedge clk);
      cur++;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, cur);
      end
  endtask

  task automatic chk_outs(input string tag, input int c, input int r, input int s, input int w);
    chk({tag, ".count"},   32'(count),   32'(c));
    chk({tag, ".running"}, 32'(running), 32'(r));
    chk({tag, ".step"},    32'(step),    32'(s));
    chk({tag, ".wrap"},    32'(wrap),    32'(w));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic saw_step;
    reset      = 1'b1;
    run        = 1'b0;
    mode       = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    load_value = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_outs("idle", 0, 0, 0, 0);

    // Start counting up; the next edge is edge 0.
    run  = 1'b1;
    mode = 1'b0;
    cur  = -1;
    go_to(0);
    chk_outs("start", 0, 1, 0, 0);
    go_to(9);
    chk_outs("pre_first_step", 0, 1, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      go_to(10 * i);
      chk_outs("up_step", i, 1, 1, 0);
    end
    go_to(91);
    chk("step_one_cycle", 32'(step), 32'(0));
    go_to(100);
    chk_outs("up_wrap", 0, 1, 1, 1);
    go_to(101);
    chk_outs("up_wrap_after", 0, 1, 0, 0);

    // Down from 0: wrap to 9, then 8 .. 3.
    mode = 1'b1;
    go_to(110);
    chk_outs("down_wrap", 9, 1, 1, 1);
    go_to(120);
    chk_outs("down_8", 8, 1, 1, 0);
    go_to(130);
    chk_outs("down_7", 7, 1, 1, 0);
    go_to(170);
    chk_outs("down_3", 3, 1, 1, 0);

    // Stop for 25 cycles at count 3.
    run = 1'b0;
    go_to(171);
    chk_outs("stop", 3, 0, 0, 0);
    saw_step = 1'b0;
    for (int e = 172; e <= 195; e++) begin
      go_to(e);
      if (step) saw_step = 1'b1;
    end
    chk("stop_no_step", 32'(saw_step), 32'(0));
    chk_outs("stop_hold", 3, 0, 0, 0);

    // Re-run counting up: step 10 edges after the run sample (edge 196).
    mode = 1'b0;
    run  = 1'b1;
    go_to(196);
    chk_outs("rerun", 3, 1, 0, 0);
    go_to(205);
    chk_outs("rerun_pre", 3, 1, 0, 0);
    go_to(206);
    chk_outs("rerun_step", 4, 1, 1, 0);

    // Mode toggled 3 cycles before the next step at edge 216.
    go_to(213);
    mode = 1'b1;
    go_to(215);
    chk_outs("toggle_pre", 4, 1, 0, 0);
    go_to(216);
    chk_outs("toggle_step", 3, 1, 1, 0);
    go_to(217);
    chk("toggle_no_double", 32'(step), 32'(0));
    go_to(225);
    chk_outs("toggle_spacing", 3, 1, 0, 0);
    go_to(226);
    chk_outs("toggle_next", 2, 1, 1, 0);

    // Saturating load of 13 -> 9.
    go_to(227);
    load       = 1'b1;
    load_value = 4'd13;
    go_to(228);
    load = 1'b0;
    chk_outs("load_sat", 9, 1, 0, 0);

    // Load coinciding with the step edge 238: load wins, no pulses.
    go_to(237);
    chk_outs("load_pre_step", 9, 1, 0, 0);
    load       = 1'b1;
    load_value = 4'd5;
    go_to(238);
    load = 1'b0;
    chk_outs("load_vs_step", 5, 1, 0, 0);
    go_to(248);
    chk_outs("load_restart", 4, 1, 1, 0);

    // Clear and load together at count 7: clear wins.
    load       = 1'b1;
    load_value = 4'd7;
    go_to(249);
    chk_outs("load_7", 7, 1, 0, 0);
    clear      = 1'b1;
    load_value = 4'd3;
    go_to(250);
    clear = 1'b0;
    load  = 1'b0;
    chk_outs("clear_wins", 0, 1, 0, 0);
    go_to(259);
    chk_outs("clear_pre_step", 0, 1, 0, 0);
    go_to(260);
    chk_outs("clear_then_wrap", 9, 1, 1, 1);

    // Asynchronous reset mid-run at count 6.
    load       = 1'b1;
    load_value = 4'd6;
    go_to(261);
    load = 1'b0;
    chk_outs("load_6", 6, 1, 0, 0);
    go_to(263);
    #2;
    reset = 1'b1;
    #1;
    chk_outs("async_reset", 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_outs("after_reset", 0, 0, 0, 0);
    // run is still 1; the next edge is a fresh run sample.
    cur = 263;
    go_to(264);
    chk_outs("reset_rerun", 0, 1, 0, 0);
    go_to(273);
    chk_outs("reset_rerun_pre", 0, 1, 0, 0);
    go_to(274);
    chk_outs("reset_rerun_step", 9, 1, 1, 1);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_updown_counter_ctrl
